icache: RTL

Direct-mapped, read-only instruction cache between the instruction queue (fetch side) and the instruction memory port. It accepts one word-aligned fetch address per cycle and answers hits with a single-cycle pulse one cycle after acceptance. On a miss it fills the whole line from memory, one word at a time, before answering. A flush input invalidates every line, for `fence.i`.

---
 rtl/icache.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache. Hits answer one cycle after
// acceptance; misses fill the whole line word by word before answering.
module icache #(
    parameter int INDEX_WIDTH  = 4,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ireq_valid,
    output logic        ireq_ready,
    input  logic [31:0] ireq_addr,
    output logic        iresp_valid,
    output logic [31:0] iresp_addr,
    output logic [31:0] iresp_inst,
    input  logic        flush,
    output logic        mreq_valid,
    input  logic        mreq_ready,
    output logic [31:0] mreq_addr,
    input  logic        mresp_valid,
    input  logic [31:0] mresp_addr,
    input  logic [31:0] mresp_inst
);
    localparam int TAG_W = 30 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int WORDS = 1 << OFFSET_WIDTH;
    localparam logic [OFFSET_WIDTH-1:0] CNT_ONE  = 1;
    localparam logic [OFFSET_WIDTH-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_WAIT} state_t;

    state_t                  state_q, state_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [31:0]             req_addr_q, req_addr_d;
    logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
    logic                    flush_pend_q, flush_pend_d;
    logic                    iresp_valid_q, iresp_valid_d;
    logic [31:0]             iresp_addr_q, iresp_addr_d;
    logic [31:0]             iresp_inst_q, iresp_inst_d;
    logic [31:0]             mreq_addr_q, mreq_addr_d;
    logic [31:0]             word_q, word_d;

    logic [TAG_W-1:0]        tag_q  [LINES];
    logic [31:0]             data_q [LINES*WORDS];

    logic [TAG_W-1:0]        req_tag, fill_tag;
    logic [INDEX_WIDTH-1:0]  req_idx, fill_idx;
    logic [OFFSET_WIDTH-1:0] req_off, fill_off;
    logic                    hit, fill_we, tag_we, mresp_match;

    assign req_tag  = ireq_addr[31:INDEX_WIDTH+OFFSET_WIDTH+2];
    assign req_idx  = ireq_addr[INDEX_WIDTH+OFFSET_WIDTH+1:OFFSET_WIDTH+2];
    assign req_off  = ireq_addr[OFFSET_WIDTH+1:2];
    assign fill_tag = req_addr_q[31:INDEX_WIDTH+OFFSET_WIDTH+2];
    assign fill_idx = req_addr_q[INDEX_WIDTH+OFFSET_WIDTH+1:OFFSET_WIDTH+2];
    assign fill_off = req_addr_q[OFFSET_WIDTH+1:2];

    assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign mresp_match = mresp_valid && (mresp_addr == mreq_addr_q);

    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        req_addr_d    = req_addr_q;
        cnt_d         = cnt_q;
        flush_pend_d  = flush_pend_q;
        iresp_valid_d = 1'b0;
        iresp_addr_d  = iresp_addr_q;
        iresp_inst_d  = iresp_inst_q;
        mreq_addr_d   = mreq_addr_q;
        word_d        = word_q;
        ireq_ready    = 1'b0;
        mreq_valid    = 1'b0;
        fill_we       = 1'b0;
        tag_we        = 1'b0;

        case (state_q)
            IDLE: begin
                ireq_ready = !flush;
                if (flush) begin
                    valid_d = '0;
                end else if (ireq_valid) begin
                    if (hit) begin
                        iresp_valid_d = 1'b1;
                        iresp_addr_d  = ireq_addr & ~32'h3;
                        iresp_inst_d  = data_q[{req_idx, req_off}];
                    end else begin
                        req_addr_d  = ireq_addr & ~32'h3;
                        cnt_d       = '0;
                        mreq_addr_d = {req_tag, req_idx, {OFFSET_WIDTH{1'b0}}, 2'b00};
                        state_d     = FILL_REQ;
                    end
                end
            end
            FILL_REQ: begin
                mreq_valid = 1'b1;
                if (flush) flush_pend_d = 1'b1;
                if (mreq_ready) state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (flush) flush_pend_d = 1'b1;
                if (mresp_match) begin
                    fill_we = 1'b1;
                    if (cnt_q == fill_off) word_d = mresp_inst;
                    if (cnt_q == CNT_LAST) begin
                        tag_we        = 1'b1;
                        iresp_valid_d = 1'b1;
                        iresp_addr_d  = req_addr_q;
                        iresp_inst_d  = (cnt_q == fill_off) ? mresp_inst : word_q;
                        state_d       = IDLE;
                        // A flush seen at any point of the fill also drops the line just filled
                        if (flush_pend_q || flush) begin
                            valid_d      = '0;
                            flush_pend_d = 1'b0;
                        end else begin
                            valid_d[fill_idx] = 1'b1;
                        end
                    end else begin
                        cnt_d       = cnt_q + CNT_ONE;
                        mreq_addr_d = {fill_tag, fill_idx, cnt_q + CNT_ONE, 2'b00};
                        state_d     = FILL_REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            req_addr_q    <= '0;
            cnt_q         <= '0;
            flush_pend_q  <= 1'b0;
            iresp_valid_q <= 1'b0;
            iresp_addr_q  <= '0;
            iresp_inst_q  <= '0;
            mreq_addr_q   <= '0;
            word_q        <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            req_addr_q    <= req_addr_d;
            cnt_q         <= cnt_d;
            flush_pend_q  <= flush_pend_d;
            iresp_valid_q <= iresp_valid_d;
            iresp_addr_q  <= iresp_addr_d;
            iresp_inst_q  <= iresp_inst_d;
            mreq_addr_q   <= mreq_addr_d;
            word_q        <= word_d;
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify them
    always_ff @(posedge clk) begin
        if (fill_we) data_q[{fill_idx, cnt_q}] <= mresp_inst;
        if (tag_we)  tag_q[fill_idx]           <= fill_tag;
    end

    assign iresp_valid = iresp_valid_q;
    assign iresp_addr  = iresp_addr_q;
    assign iresp_inst  = iresp_inst_q;
    assign mreq_addr   = mreq_addr_q;

endmodule
